// File: rtl/axis2xgmii32.sv
// AXI-Stream to 32-bit XGMII TX framer: preamble/SFD insertion, optional minimum-size
// padding, CRC-32 FCS append, terminate, inter-frame gap, underrun abort.
module axis2xgmii32 #(
   parameter int P_PAD_EN    = 1,
   parameter int P_IFG_WORDS = 2
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:0] tdata_i,
   input  logic [1:0]  tvldb_i,
   input  logic        tvalid_i,
   input  logic        tlast_i,
   output logic        tready_o,
   input  logic        xgmii_rdy_i,
   output logic [31:0] xgmii_d_o,
   output logic [3:0]  xgmii_c_o,
   output logic [31:0] frames_o,
   output logic [31:0] underruns_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_PREAMBLE, S_DATA, S_PAD, S_FCS, S_TERM, S_IFG, S_DROP
   } state_t;

   localparam logic [31:0] IDLE_D  = 32'h07070707;
   localparam logic [31:0] START_D = 32'h555555FB;
   localparam logic [31:0] PRE_D   = 32'hD5555555;
   localparam logic [31:0] ERR_D   = 32'hFEFEFEFE;
   localparam logic [15:0] IFG_LAST = 16'(P_IFG_WORDS - 1);
   localparam state_t      AFTER_TERM = (P_IFG_WORDS == 0) ? S_IDLE : S_IFG;

   state_t      state, state_nxt;
   logic [31:0] crc, crc_nxt;
   logic [6:0]  cnt, cnt_nxt;
   logic [1:0]  rem, rem_nxt;
   logic [15:0] ifg_cnt, ifg_nxt;
   logic [31:0] d_nxt, frames_nxt, under_nxt;
   logic [3:0]  c_nxt;

   logic [2:0]  n_vld;
   logic [31:0] beat_masked, crc_part, crc_full, crc_zero, fcs_part, fcs_reg;
   logic [31:0] fcs_ins, fcs_tail;
   logic [7:0]  total;
   logic        need_pad;

   // Reflected CRC-32 (poly 0x04C11DB7) over the low nbytes lanes of a word, lane 0 first.
   function automatic logic [31:0] crc_upd(input logic [31:0] crc_in,
                                           input logic [31:0] word,
                                           input logic [2:0]  nbytes);
      logic [31:0] c;
      c = crc_in;
      for (int b = 0; b < 4; b++) begin
         if (b < int'(nbytes)) begin
            c = c ^ {24'h0, word[8*b +: 8]};
            for (int j = 0; j < 8; j++)
               c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return c;
   endfunction

   function automatic logic [6:0] cnt_add(input logic [6:0] c, input logic [2:0] n);
      logic [7:0] s;
      s = {1'b0, c} + {5'h0, n};
      return (s > 8'd127) ? 7'd127 : s[6:0];
   endfunction

   assign tready_o = xgmii_rdy_i && ((state == S_DATA) || (state == S_DROP));

   always_comb begin
      n_vld = tlast_i ? ({1'b0, tvldb_i} + 3'd1) : 3'd4;
      beat_masked = 32'h0;
      for (int i = 0; i < 4; i++)
         beat_masked[8*i +: 8] = (3'(i) < n_vld) ? tdata_i[8*i +: 8] : 8'h00;
      total    = {1'b0, cnt} + {5'h0, n_vld};
      need_pad = (P_PAD_EN != 0) && tlast_i && (total < 8'd60);
      crc_part = crc_upd(crc, beat_masked, n_vld);
      crc_full = crc_upd(crc, beat_masked, 3'd4);
      crc_zero = crc_upd(crc, 32'h0, 3'd4);
      fcs_part = ~crc_part;
      fcs_reg  = ~crc;
      // FCS bytes shifted so lane k onward holds FCS byte 0 onward.
      fcs_ins  = fcs_part << {n_vld, 3'b000};
      // Remaining FCS bytes moved down to lane 0 for the terminate word.
      fcs_tail = fcs_reg >> {(3'd4 - {1'b0, rem}), 3'b000};
   end

   always_comb begin
      state_nxt  = state;
      crc_nxt    = crc;
      cnt_nxt    = cnt;
      rem_nxt    = rem;
      ifg_nxt    = ifg_cnt;
      d_nxt      = xgmii_d_o;
      c_nxt      = xgmii_c_o;
      frames_nxt = frames_o;
      under_nxt  = underruns_o;
      case (state)
         S_IDLE: begin
            d_nxt = IDLE_D;
            c_nxt = 4'hF;
            if (tvalid_i) begin
               d_nxt     = START_D;
               c_nxt     = 4'h1;
               state_nxt = S_PREAMBLE;
            end
         end
         S_PREAMBLE: begin
            d_nxt     = PRE_D;
            c_nxt     = 4'h0;
            crc_nxt   = 32'hFFFFFFFF;
            cnt_nxt   = 7'd0;
            rem_nxt   = 2'd0;
            state_nxt = S_DATA;
         end
         S_DATA: begin
            if (!tvalid_i) begin
               d_nxt     = ERR_D;
               c_nxt     = 4'hF;
               under_nxt = underruns_o + 32'd1;
               state_nxt = S_DROP;
            end else begin
               c_nxt   = 4'h0;
               cnt_nxt = cnt_add(cnt, n_vld);
               if (!tlast_i) begin
                  d_nxt   = tdata_i;
                  crc_nxt = crc_part;
               end else if (need_pad) begin
                  d_nxt     = beat_masked;
                  crc_nxt   = crc_full;
                  cnt_nxt   = cnt_add(cnt, 3'd4);
                  state_nxt = (cnt_add(cnt, 3'd4) >= 7'd60) ? S_FCS : S_PAD;
               end else if (n_vld == 3'd4) begin
                  d_nxt     = tdata_i;
                  crc_nxt   = crc_part;
                  state_nxt = S_FCS;
               end else begin
                  // Short last beat: the leading FCS bytes share this word.
                  for (int i = 0; i < 4; i++)
                     d_nxt[8*i +: 8] = (3'(i) < n_vld) ? beat_masked[8*i +: 8]
                                                       : fcs_ins[8*i +: 8];
                  crc_nxt   = crc_part;
                  rem_nxt   = n_vld[1:0];
                  state_nxt = S_TERM;
               end
            end
         end
         S_PAD: begin
            d_nxt   = 32'h0;
            c_nxt   = 4'h0;
            crc_nxt = crc_zero;
            cnt_nxt = cnt_add(cnt, 3'd4);
            if (cnt_add(cnt, 3'd4) >= 7'd60)
               state_nxt = S_FCS;
         end
         S_FCS: begin
            d_nxt     = fcs_reg;
            c_nxt     = 4'h0;
            rem_nxt   = 2'd0;
            state_nxt = S_TERM;
         end
         S_TERM: begin
            for (int i = 0; i < 4; i++) begin
               if (2'(i) < rem) begin
                  d_nxt[8*i +: 8] = fcs_tail[8*i +: 8];
                  c_nxt[i]        = 1'b0;
               end else if (2'(i) == rem) begin
                  d_nxt[8*i +: 8] = 8'hFD;
                  c_nxt[i]        = 1'b1;
               end else begin
                  d_nxt[8*i +: 8] = 8'h07;
                  c_nxt[i]        = 1'b1;
               end
            end
            frames_nxt = frames_o + 32'd1;
            ifg_nxt    = 16'd0;
            state_nxt  = AFTER_TERM;
         end
         S_IFG: begin
            d_nxt = IDLE_D;
            c_nxt = 4'hF;
            if (ifg_cnt == IFG_LAST)
               state_nxt = S_IDLE;
            else
               ifg_nxt = ifg_cnt + 16'd1;
         end
         S_DROP: begin
            d_nxt = IDLE_D;
            c_nxt = 4'hF;
            if (tvalid_i && tlast_i) begin
               ifg_nxt   = 16'd0;
               state_nxt = AFTER_TERM;
            end
         end
         default: begin
            d_nxt     = IDLE_D;
            c_nxt     = 4'hF;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= S_IDLE;
         crc         <= 32'hFFFFFFFF;
         cnt         <= 7'd0;
         rem         <= 2'd0;
         ifg_cnt     <= 16'd0;
         xgmii_d_o   <= IDLE_D;
         xgmii_c_o   <= 4'hF;
         frames_o    <= 32'd0;
         underruns_o <= 32'd0;
      end else if (xgmii_rdy_i) begin
         state       <= state_nxt;
         crc         <= crc_nxt;
         cnt         <= cnt_nxt;
         rem         <= rem_nxt;
         ifg_cnt     <= ifg_nxt;
         xgmii_d_o   <= d_nxt;
         xgmii_c_o   <= c_nxt;
         frames_o    <= frames_nxt;
         underruns_o <= under_nxt;
      end
   end

endmodule

// File: tb/tb_axis2xgmii32.sv
// Directed bench for axis2xgmii32: framing, padding, FCS, IFG, underrun, stall and reset.
module tb_axis2xgmii32;

   localparam logic [35:0] W_IDLE = {4'hF, 32'h07070707};
   localparam logic [35:0] W_SOF  = {4'h1, 32'h555555FB};
   localparam logic [35:0] W_PRE  = {4'h0, 32'hD5555555};
   localparam logic [35:0] W_TERM = {4'hF, 32'h070707FD};
   localparam logic [35:0] W_ERR  = {4'hF, 32'hFEFEFEFE};

   logic        clk = 1'b0;
   logic        rst_n, tvalid, tlast, rdy, use_np, tog;
   logic [31:0] tdata;
   logic [1:0]  tvldb;
   logic        tready, tready_n, tvalid_np;
   logic [31:0] xd, xd_n, frames, frames_n, unders, unders_n;
   logic [3:0]  xc, xc_n;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [7:0]  frm [64];
   logic [35:0] exp_seq [20];
   logic [35:0] q [$];
   logic [35:0] qn [$];
   logic        rdy_q = 1'b0;

   always #5 clk = ~clk;
   assign tvalid_np = tvalid & use_np;

   axis2xgmii32 #(.P_PAD_EN(1), .P_IFG_WORDS(2)) u_dut (
      .clk_i(clk), .rst_n_i(rst_n), .tdata_i(tdata), .tvldb_i(tvldb),
      .tvalid_i(tvalid), .tlast_i(tlast), .tready_o(tready), .xgmii_rdy_i(rdy),
      .xgmii_d_o(xd), .xgmii_c_o(xc), .frames_o(frames), .underruns_o(unders));

   axis2xgmii32 #(.P_PAD_EN(0), .P_IFG_WORDS(2)) u_dut_np (
      .clk_i(clk), .rst_n_i(rst_n), .tdata_i(tdata), .tvldb_i(tvldb),
      .tvalid_i(tvalid_np), .tlast_i(tlast), .tready_o(tready_n), .xgmii_rdy_i(rdy),
      .xgmii_d_o(xd_n), .xgmii_c_o(xc_n), .frames_o(frames_n), .underruns_o(unders_n));

   // A word is new on the wire only after an edge where rdy was high.
   always @(posedge clk) rdy_q <= rdy;
   always @(negedge clk) begin
      if (rdy_q) begin
         q.push_back({xc, xd});
         qn.push_back({xc_n, xd_n});
      end
   end
   always @(negedge clk) if (tog) rdy = ~rdy;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [35:0] getw(input int i);
      if (i >= 0 && i < q.size()) return q[i];
      return 36'h0;
   endfunction

   task automatic chk_w(input string tag, input int idx, input logic [35:0] exp);
      check_eq(tag, 64'(getw(idx)), 64'(exp));
   endtask

   function automatic int find_sof(input int from);
      for (int i = (from < 0 ? 0 : from); i < q.size(); i++)
         if (q[i] == W_SOF) return i;
      return -1;
   endfunction

   function automatic logic [31:0] ref_fcs(input int n);
      logic [31:0] r;
      logic        fb;
      r = 32'hFFFFFFFF;
      for (int i = 0; i < n; i++)
         for (int bt = 0; bt < 8; bt++) begin
            fb = r[0] ^ frm[i][bt];
            r  = {1'b0, r[31:1]};
            if (fb) r = r ^ 32'hEDB88320;
         end
      return ~r;
   endfunction

   task automatic fill_pattern(input int len, input int seed);
      for (int i = 0; i < 64; i++)
         frm[i] = (i < len) ? 8'((seed + 7 * i) & 255) : 8'h00;
   endtask

   task automatic build_exp64();
      exp_seq[0] = W_SOF;
      exp_seq[1] = W_PRE;
      for (int j = 0; j < 16; j++)
         exp_seq[2+j] = {4'h0, frm[4*j+3], frm[4*j+2], frm[4*j+1], frm[4*j]};
      exp_seq[18] = {4'h0, ref_fcs(64)};
      exp_seq[19] = W_TERM;
   endtask

   task automatic send_frame(input int len, input int hole_at, input int abort_at);
      int   beats;
      int   b;
      int   waits;
      bit   hole_done;
      logic acc;
      beats = (len + 3) / 4;
      b = 0;
      waits = 0;
      hole_done = 1'b0;
      while (b < beats) begin
         @(negedge clk);
         if (b == hole_at && !hole_done) begin
            hole_done = 1'b1;
            tvalid = 1'b0;
            tlast  = 1'b0;
            @(posedge clk);
            continue;
         end
         tvalid = 1'b1;
         tlast  = (b == beats - 1);
         tvldb  = tlast ? 2'((len - 1) % 4) : 2'd1;
         for (int l = 0; l < 4; l++)
            tdata[8*l +: 8] = (4 * b + l < len) ? frm[4*b+l] : 8'hEE;
         #1;
         acc = tready;
         if (!rdy) check_eq("no_accept_when_stalled", 64'(tready), 64'(0));
         @(posedge clk);
         if (acc) begin
            b++;
            waits = 0;
         end else begin
            waits++;
            if (waits > 300) begin
               check_eq("accept_timeout", 64'(b), 64'(beats));
               break;
            end
         end
         if (abort_at >= 0 && b == abort_at) break;
      end
   endtask

   task automatic idle_cycles(input int n);
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int s, s2, n_idle;
      logic [31:0] fcs_aa;
      rst_n = 1'b0; rdy = 1'b1; tvalid = 1'b0; tlast = 1'b0;
      tdata = 32'h0; tvldb = 2'd0; use_np = 1'b0; tog = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_d", 64'(xd), 64'(32'h07070707));
      check_eq("rst_c", 64'(xc), 64'(4'hF));
      check_eq("rst_tready", 64'(tready), 64'(0));
      check_eq("rst_frames", 64'(frames), 64'(0));
      check_eq("rst_underruns", 64'(unders), 64'(0));
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // "123456789" without padding: FCS 0xCBF43926 split across the last two words
      for (int i = 0; i < 64; i++) frm[i] = (i < 9) ? 8'(8'h31 + i) : 8'h00;
      use_np = 1'b1;
      q.delete(); qn.delete();
      send_frame(9, -1, -1);
      idle_cycles(40);
      use_np = 1'b0;
      q = qn;
      s = find_sof(0);
      check_eq("t1_sof_found", 64'(s >= 0), 64'(1));
      chk_w("t1_pre", s + 1, W_PRE);
      chk_w("t1_d0", s + 2, {4'h0, 32'h34333231});
      chk_w("t1_d1", s + 3, {4'h0, 32'h38373635});
      chk_w("t1_d2_fcs", s + 4, {4'h0, 32'hF4392639});
      chk_w("t1_term", s + 5, {4'hE, 32'h0707FDCB});
      chk_w("t1_idle", s + 6, W_IDLE);
      check_eq("t1_frames_np", 64'(frames_n), 64'(1));
      check_eq("t1_frames", 64'(frames), 64'(1));

      // 1-byte padded frame followed back-to-back by a 64-byte frame
      for (int i = 0; i < 64; i++) frm[i] = 8'h00;
      frm[0] = 8'hAA;
      fcs_aa = ref_fcs(60);
      q.delete();
      send_frame(1, -1, -1);
      fill_pattern(64, 3);
      build_exp64();
      send_frame(64, -1, -1);
      idle_cycles(40);
      s = find_sof(0);
      check_eq("t2_sof_found", 64'(s >= 0), 64'(1));
      chk_w("t2_pre", s + 1, W_PRE);
      chk_w("t2_d0", s + 2, {4'h0, 32'h000000AA});
      for (int j = 3; j < 17; j++) chk_w("t2_pad", s + j, 36'h0);
      chk_w("t2_fcs", s + 17, {4'h0, fcs_aa});
      chk_w("t2_term", s + 18, W_TERM);
      n_idle = 0;
      while (s + 19 + n_idle < q.size() && getw(s + 19 + n_idle) == W_IDLE) n_idle++;
      check_eq("t2_ifg_ge2", 64'(n_idle >= 2), 64'(1));
      s2 = s + 19 + n_idle;
      for (int k = 0; k < 20; k++) chk_w("t3_word", s2 + k, exp_seq[k]);
      check_eq("t3_frames", 64'(frames), 64'(3));

      // underrun after three beats, rest of frame discarded through tlast
      fill_pattern(24, 5);
      q.delete();
      send_frame(24, 3, -1);
      idle_cycles(40);
      s = find_sof(0);
      chk_w("t4_d0", s + 2, {4'h0, frm[3], frm[2], frm[1], frm[0]});
      chk_w("t4_d2", s + 4, {4'h0, frm[11], frm[10], frm[9], frm[8]});
      chk_w("t4_err", s + 5, W_ERR);
      chk_w("t4_idle", s + 6, W_IDLE);
      check_eq("t4_no_restart", 64'(find_sof(s + 1)), 64'(-1));
      check_eq("t4_underruns", 64'(unders), 64'(1));
      check_eq("t4_frames", 64'(frames), 64'(3));

      // 64-byte frame with rdy toggling every cycle
      fill_pattern(64, 3);
      build_exp64();
      q.delete();
      tog = 1'b1;
      send_frame(64, -1, -1);
      idle_cycles(80);
      tog = 1'b0;
      @(negedge clk);
      rdy = 1'b1;
      s = find_sof(0);
      check_eq("t5_sof_found", 64'(s >= 0), 64'(1));
      for (int k = 0; k < 20; k++) chk_w("t5_word", s + k, exp_seq[k]);
      check_eq("t5_frames", 64'(frames), 64'(4));

      // asynchronous reset in the middle of DATA
      q.delete();
      send_frame(64, -1, 5);
      #3 rst_n = 1'b0;
      #1;
      check_eq("t6_rst_d", 64'(xd), 64'(32'h07070707));
      check_eq("t6_rst_c", 64'(xc), 64'(4'hF));
      check_eq("t6_rst_tready", 64'(tready), 64'(0));
      check_eq("t6_rst_frames", 64'(frames), 64'(0));
      check_eq("t6_rst_underruns", 64'(unders), 64'(0));
      tvalid = 1'b0;
      tlast  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 64; i++) frm[i] = 8'h00;
      frm[0] = 8'hAA;
      q.delete();
      send_frame(1, -1, -1);
      idle_cycles(40);
      s = find_sof(0);
      check_eq("t6_sof_found", 64'(s >= 0), 64'(1));
      chk_w("t6_pre", s + 1, W_PRE);
      chk_w("t6_d0", s + 2, {4'h0, 32'h000000AA});
      chk_w("t6_fcs", s + 17, {4'h0, fcs_aa});
      chk_w("t6_term", s + 18, W_TERM);
      check_eq("t6_frames", 64'(frames), 64'(1));
      check_eq("t6_underruns", 64'(unders), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
